// File: rtl/channel_sum_reduce.sv
// -----------------------------------------------------------------------------
// channel_sum_reduce
//
// Streaming reduction engine. After reset it clears its accumulator, pops
// N_ITEMS words from an input FIFO channel (one word per iteration), adds each
// into the accumulator, pushes the final sum once to an output FIFO channel
// and then raises a sticky valid flag until the next reset.
//
// Build option:
//   CHANNEL_SUM_SAT_EN  when defined, each add saturates to all-ones on
//                       unsigned carry-out instead of wrapping. Cycle timing
//                       is the same in both builds.
//
// Parameters:
//   WIDTH    data width of both channels and of the accumulator
//   N_ITEMS  number of input words reduced (1 <= N_ITEMS < 2**WIDTH)
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous, active-high reset
//   valid            sticky: result has been written to the output channel
//   in_out_data      input channel read data (word popped on the previous cycle)
//   in_read_ready    input channel has a word available
//   in_write_ready   unused
//   in_read_valid    one-cycle pop strobe to the input channel
//   in_in_data       tied 0
//   in_write_valid   tied 0
//   in_rst           tied 0
//   out_out_data     unused
//   out_read_ready   unused
//   out_write_ready  output channel can accept a word
//   out_in_data      output write data, always equal to the accumulator
//   out_write_valid  one-cycle push strobe to the output channel
//   out_read_valid   tied 0
//   out_rst          tied 0
// -----------------------------------------------------------------------------
module channel_sum_reduce #(
   parameter int WIDTH   = 32,
   parameter int N_ITEMS = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic             valid,
   // input channel
   input  logic [WIDTH-1:0] in_out_data,
   input  logic             in_read_ready,
   input  logic             in_write_ready,
   output logic             in_read_valid,
   output logic [WIDTH-1:0] in_in_data,
   output logic             in_write_valid,
   output logic             in_rst,
   // output channel
   input  logic [WIDTH-1:0] out_out_data,
   input  logic             out_read_ready,
   input  logic             out_write_ready,
   output logic [WIDTH-1:0] out_in_data,
   output logic             out_write_valid,
   output logic             out_read_valid,
   output logic             out_rst
);

   typedef enum logic [3:0] {
      S0_INIT      = 4'd0,
      S1_LOOP      = 4'd1,
      S2_WAIT_IN   = 4'd2,
      S3_POP       = 4'd3,
      S4_ADD       = 4'd4,
      S5_BRANCH    = 4'd5,
      S6_WAIT_OUT  = 4'd6,
      S7_PUSH      = 4'd7,
      S8_DONE      = 4'd8
   } state_t;

   localparam logic [WIDTH-1:0] N_LAST = WIDTH'(N_ITEMS);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] cnt_q;
   logic             done_q;

   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] sum_word;

   assign cnt_inc = cnt + WIDTH'(1);

   // One extra bit captures the unsigned carry-out of the add.
   assign sum_ext = {1'b0, acc_q} + {1'b0, in_out_data};

`ifdef CHANNEL_SUM_SAT_EN
   assign sum_word = sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];
`else
   assign sum_word = sum_ext[WIDTH-1:0];
`endif

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= S0_INIT;
      else     state <= state_next;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: the default assignment at the top covers every path through the
   // case, so no latch is inferred for state_next.
   always_comb begin
      state_next = state;
      unique case (state)
         S0_INIT:     state_next = S1_LOOP;
         S1_LOOP:     state_next = S2_WAIT_IN;
         S2_WAIT_IN:  if (in_read_ready) state_next = S3_POP;
         S3_POP:      state_next = S4_ADD;
         S4_ADD:      state_next = S5_BRANCH;
         S5_BRANCH:   state_next = done_q ? S6_WAIT_OUT : S2_WAIT_IN;
         S6_WAIT_OUT: if (out_write_ready) state_next = S7_PUSH;
         S7_PUSH:     state_next = S8_DONE;
         S8_DONE:     state_next = S8_DONE;
         default:     state_next = S0_INIT;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   // acc_q holds the accumulator snapshot taken when an item is accepted; the
   // add in S4 uses it together with the word the channel returns after the pop.
   // done_q remembers whether the item just accepted is the last one, so the
   // S5 branch needs no comparator on its own path.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         cnt    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         case (state)
            S0_INIT:    acc <= '0;
            S1_LOOP:    cnt <= '0;
            S2_WAIT_IN: begin
               if (in_read_ready) begin
                  acc_q  <= acc;
                  cnt_q  <= cnt;
                  cnt    <= cnt_inc;
                  done_q <= (cnt_inc == N_LAST);
               end
            end
            S4_ADD:     acc <= sum_word;
            default:    ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: strobes and flag are pure decodes of the state register.
   // ---------------------------------------------------------------------------
   assign in_read_valid   = (state == S3_POP);
   assign out_write_valid = (state == S7_PUSH);
   assign valid           = (state == S8_DONE);
   assign out_in_data     = acc;

   assign in_in_data      = '0;
   assign in_write_valid  = 1'b0;
   assign in_rst          = 1'b0;
   assign out_read_valid  = 1'b0;
   assign out_rst         = 1'b0;

   // Inputs the block never consumes, the carry bit in the wrapping build and
   // the per-item index snapshot (kept for debug visibility) are folded here.
   logic unused_sink;
   assign unused_sink = ^{in_write_ready, out_out_data, out_read_ready,
                          sum_ext[WIDTH], cnt_q};

endmodule

// File: tb/tb_channel_sum_reduce.sv
// -----------------------------------------------------------------------------
// tb_channel_sum_reduce
//
// Self-checking bench for channel_sum_reduce (WIDTH=32, N_ITEMS=4). Each case
// fills a per-cycle ready schedule for both channels and a list of input
// words, runs the DUT from reset and records every strobe by cycle number
// (cycle 0 = first cycle after reset release). A reference model derives
// expected pop cycles, push cycle, valid cycle and the sum directly from the
// schedule and the word list. The input channel is modelled as a FIFO with
// one cycle read latency: the popped word appears on in_out_data only in the
// cycle after the pop strobe and random data is shown otherwise.
// -----------------------------------------------------------------------------
module tb_channel_sum_reduce;

   localparam int WIDTH = 32;
   localparam int N     = 4;
   localparam int MAXC  = 400;
   localparam int HOLD  = 50;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             valid;
   logic [WIDTH-1:0] in_out_data = '0;
   logic             in_read_ready = 1'b0;
   logic             in_write_ready = 1'b0;
   logic             in_read_valid;
   logic [WIDTH-1:0] in_in_data;
   logic             in_write_valid;
   logic             in_rst;
   logic [WIDTH-1:0] out_out_data = '0;
   logic             out_read_ready = 1'b0;
   logic             out_write_ready = 1'b0;
   logic [WIDTH-1:0] out_in_data;
   logic             out_write_valid;
   logic             out_read_valid;
   logic             out_rst;

   channel_sum_reduce #(.WIDTH(WIDTH), .N_ITEMS(N)) dut (
      .clk             (clk),
      .rst             (rst),
      .valid           (valid),
      .in_out_data     (in_out_data),
      .in_read_ready   (in_read_ready),
      .in_write_ready  (in_write_ready),
      .in_read_valid   (in_read_valid),
      .in_in_data      (in_in_data),
      .in_write_valid  (in_write_valid),
      .in_rst          (in_rst),
      .out_out_data    (out_out_data),
      .out_read_ready  (out_read_ready),
      .out_write_ready (out_write_ready),
      .out_in_data     (out_in_data),
      .out_write_valid (out_write_valid),
      .out_read_valid  (out_read_valid),
      .out_rst         (out_rst)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   bit               rr [MAXC];
   bit               wr [MAXC];
   logic [WIDTH-1:0] items [N];
   logic [WIDTH-1:0] chan_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sum of the word list, one add at a time, wrapping or clamping at 2**32.
   function automatic logic [WIDTH-1:0] ref_sum();
      longint unsigned s = 0;
      for (int i = 0; i < N; i++) begin
         s = s + longint'(items[i]);
`ifdef CHANNEL_SUM_SAT_EN
         if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`else
         s = s & 64'hFFFF_FFFF;
`endif
      end
      return s[WIDTH-1:0];
   endfunction

   task automatic set_readies(input int rr_at, input int rr_len, input int wr_at, input int wr_len);
      for (int c = 0; c < MAXC; c++) begin
         rr[c] = !(c >= rr_at && c < rr_at + rr_len);
         wr[c] = !(c >= wr_at && c < wr_at + wr_len);
      end
   endtask

   task automatic random_readies();
      for (int c = 0; c < MAXC; c++) begin
         rr[c] = ($urandom_range(0, 9) < 7);
         wr[c] = ($urandom_range(0, 9) < 7);
      end
   endtask

   // Timing model: the block first waits for input two cycles after reset
   // release; an accepted item is popped the next cycle and the block waits
   // again four cycles after it was accepted. After the last item the output
   // wait begins four cycles after acceptance, the push follows one cycle
   // after the output ready is seen, and valid one cycle after the push.
   task automatic ref_timeline(output int pop_c [N], output int w_c, output int v_c);
      int t = 2;
      for (int k = 0; k < N; k++) begin
         while (t < MAXC && !rr[t]) t++;
         pop_c[k] = t + 1;
         t = t + 4;
      end
      while (t < MAXC && !wr[t]) t++;
      w_c = t + 1;
      v_c = t + 2;
   endtask

   // abort_at >= 0: reset is asserted during that cycle and the case stops.
   task automatic run_case(input string tag, input int abort_at);
      int               exp_pop [N];
      int               exp_w;
      int               exp_v;
      logic [WIDTH-1:0] exp_sum;
      int               pops [$];
      int               wcount = 0;
      int               wcyc = -1;
      logic [WIDTH-1:0] wdata = '0;
      int               vfirst = -1;
      logic [WIDTH-1:0] hold_data = '0;
      int               hold_err = 0;
      int               tie_err = 0;
      int               valid_drop = 0;
      bit               pop_prev = 1'b0;
      logic [7:0]       flags;

      ref_timeline(exp_pop, exp_w, exp_v);
      exp_sum = ref_sum();
      // Once done, both readies toggle randomly; they must have no effect.
      for (int c = (exp_v < 0 ? 0 : exp_v); c < MAXC; c++) begin
         rr[c] = 1'($urandom_range(0, 1));
         wr[c] = 1'($urandom_range(0, 1));
      end
      chan_q = {};
      for (int i = 0; i < N; i++) chan_q.push_back(items[i]);

      // Reset cycle: every output must be low/zero.
      rst             = 1'b1;
      in_read_ready   = 1'b0;
      out_write_ready = 1'b0;
      in_out_data     = $urandom;
      @(posedge clk);
      @(negedge clk);
      flags = {valid, in_read_valid, out_write_valid, in_write_valid,
               in_rst, out_read_valid, out_rst, |in_in_data};
      check({tag, " reset flags"}, 32'(flags), 32'h0);
      check({tag, " reset data"}, out_in_data, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int c = 0; c < MAXC; c++) begin
         in_read_ready   = rr[c];
         out_write_ready = wr[c];
         if (pop_prev && chan_q.size() > 0) in_out_data = chan_q.pop_front();
         else                               in_out_data = $urandom;
         if (c == abort_at) rst = 1'b1;
         @(negedge clk);
         pop_prev = in_read_valid;
         if (in_read_valid) pops.push_back(c);
         if (out_write_valid) begin
            wcount++;
            wcyc  = c;
            wdata = out_in_data;
         end
         if ({in_write_valid, in_rst, out_read_valid, out_rst} != 4'b0 || in_in_data != '0)
            tie_err++;
         if (vfirst >= 0) begin
            if (!valid) valid_drop++;
            if (in_read_valid || out_write_valid || out_in_data !== hold_data) hold_err++;
         end else if (valid) begin
            vfirst    = c;
            hold_data = out_in_data;
         end
         if (vfirst >= 0 && c >= vfirst + HOLD) break;
         @(posedge clk);
         #1;
         if (c == abort_at) break;
      end

      check({tag, " tie-offs"}, tie_err, 0);
      if (abort_at >= 0) begin
         check({tag, " pops before abort"}, pops.size(), 3);
         check({tag, " push before abort"}, wcount, 0);
         check({tag, " valid before abort"}, vfirst, -1);
      end else begin
         check({tag, " pop count"}, pops.size(), N);
         for (int k = 0; k < N && k < pops.size(); k++)
            check($sformatf("%s pop%0d cycle", tag, k), pops[k], exp_pop[k]);
         check({tag, " push count"}, wcount, 1);
         check({tag, " push cycle"}, wcyc, exp_w);
         check({tag, " push data"}, wdata, exp_sum);
         check({tag, " valid cycle"}, vfirst, exp_v);
         check({tag, " valid sticky"}, valid_drop, 0);
         check({tag, " quiet after done"}, hold_err, 0);
      end
   endtask

   initial begin
      // Both readies high: pops 3,7,11,15, push 19 with 10, valid from 20.
      items = '{32'd1, 32'd2, 32'd3, 32'd4};
      set_readies(-1, 0, -1, 0);
      run_case("seq1234", -1);

      // Input ready low for 5 cycles while waiting for item 2.
      items = '{32'd5, 32'd5, 32'd5, 32'd5};
      set_readies(6, 5, -1, 0);
      run_case("in_stall", -1);

      // Output ready low for 3 cycles at the output wait.
      items = '{32'd100, 32'd20, 32'd3, 32'd7};
      set_readies(-1, 0, 18, 3);
      run_case("out_stall", -1);

      // Carry-out: wraps to 1, or clamps to all-ones in the saturating build.
      items = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};
      set_readies(-1, 0, -1, 0);
      run_case("overflow", -1);

      // Reset during the third iteration, then a fresh run that must give 4.
      items = '{32'd9, 32'd9, 32'd9, 32'd9};
      set_readies(-1, 0, -1, 0);
      run_case("abort", 12);
      items = '{32'd1, 32'd1, 32'd1, 32'd1};
      run_case("restart", -1);

      // Random words and random ready patterns on both channels.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++)
            items[i] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 1000));
         random_readies();
         run_case($sformatf("rand%0d", r), -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/channel_sum_reduce.md
Name: channel_sum_reduce

Overview:
- Multi-cycle streaming reduction engine.
- Resets an internal accumulator to 0, then pulls N_ITEMS words from an input channel and adds each one into the accumulator.
- Writes the final sum once to an output channel, then raises a sticky done/valid flag.
- Sits between two FIFO-style channel interfaces. Built from a 32-bit adder, an equality comparator, a single-entry accumulator register and a one-hot-free state machine.

Parameters:
- WIDTH, 32, data width of channels and accumulator.
- N_ITEMS, 4, number of input words reduced; must be ≥1 and < 2^WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid  out  1  high once the reduction is complete and the result has been written; sticky.
- in_out_data  in  WIDTH  input channel read data.
- in_read_ready  in  1  input channel has data available.
- in_write_ready  in  1  unused.
- in_read_valid  out  1  one-cycle pop strobe to the input channel.
- in_in_data  out  WIDTH  tied 0.
- in_write_valid  out  1  tied 0.
- in_rst  out  1  tied 0.
- out_out_data  in  WIDTH  unused.
- out_read_ready  in  1  unused.
- out_write_ready  in  1  output channel can accept a word.
- out_in_data  out  WIDTH  output write data; continuously equals the accumulator.
- out_write_valid  out  1  one-cycle push strobe to the output channel.
- out_read_valid  out  1  tied 0.
- out_rst  out  1  tied 0.

Behaviour:
- Registers: state S0..S8, acc (WIDTH), cnt (WIDTH, iteration counter), snapshot regs acc_q, cnt_q, done_q.
- On rst:
  - state = S0; acc, cnt, snapshot regs = 0.
  - All outputs low/0 during and after the reset cycle.
- S0 (init): acc <= 0 → S1.
- S1 (loop entry): cnt <= 0 → S2.
- S2 (wait input): stays while in_read_ready = 0. When in_read_ready = 1:
  - acc_q <= acc
  - cnt <= cnt+1
  - done_q <= (cnt+1 == N_ITEMS)
  - → S3.
- S3: in_read_valid = 1 for exactly this cycle → S4.
- S4: in_out_data is sampled (the word popped in S3); acc <= acc_q + in_out_data, mod 2^WIDTH → S5.
- S5 (branch): done_q ? S6 : S2.
- S6 (wait output): stays while out_write_ready = 0, else → S7.
- S7: out_write_valid = 1 for exactly this cycle; out_in_data = final acc → S8.
- S8 (done): valid = 1. The block stays in S8 until rst; no further strobes.
- Strobe rules:
  - in_read_valid is high only in S3; out_write_valid is high only in S7; valid is high only in S8. All are combinational decodes of state.
- Latency: with both readies held high, S0 occurs at cycle 0 after reset release.
  - Per item 4 cycles; in_read_valid pulses at cycles 3, 7, 11, … (3+4k).
  - out_write_valid at cycle 2+4·N_ITEMS+1; valid from cycle 2+4·N_ITEMS+2 onward.
  - For N_ITEMS=4: out_write_valid at cycle 19, valid from cycle 20.
- Overflow: the sum wraps modulo 2^WIDTH (base build).
- Ready deasserting outside S2/S6 has no effect.
- rst at any state, including mid-loop, returns to S0 next cycle and discards the partial sum.

Optional Feature:
- Macro CHANNEL_SUM_SAT_EN.
- Defined: the S4 add saturates to 2^WIDTH−1 on unsigned carry-out.
- Undefined: wrap-around add.
- Timing is identical in both builds.

Test Plan:
- Readies held 1, inputs 1,2,3,4 → in_read_valid at cycles 3,7,11,15; out_write_valid at 19 with out_in_data=10; valid=1 from cycle 20 onward.
- in_read_ready=0 for 5 cycles before item 2, inputs 5,5,5,5 → FSM holds in S2 and no strobe while low; all later events shift by 5 cycles; result 20.
- out_write_ready low for 3 cycles at S6 → out_write_valid delayed by 3 cycles, pulses once with the correct sum; valid follows next cycle.
- Inputs 0xFFFFFFFF,2,0,0 → result 0x00000001 without the macro; 0xFFFFFFFF with CHANNEL_SUM_SAT_EN.
- rst asserted in the third iteration, then inputs 1,1,1,1 → no out_write_valid before restart; final result 4, not including earlier data.
- After valid=1, hold 50 cycles toggling both readies → valid stays 1; in_read_valid and out_write_valid stay 0; out_in_data stays constant.
